// File: rtl/param_updown_counter_pkg.sv
// Shared constants for the up/down counter family: end-of-range behaviour
// and count direction encodings.
package counter_pkg;

    localparam int   MODE_WRAP = 0;
    localparam int   MODE_SAT  = 1;

    localparam logic DIR_DOWN  = 1'b0;
    localparam logic DIR_UP    = 1'b1;

endpackage

// File: rtl/param_updown_counter_if.sv
// Control and status bundle of the up/down counter; master drives the
// controls, slave (the counter) returns count and flags.
interface param_updown_counter_if #(
    parameter int WIDTH = 4
);
    logic             enable;
    logic             up_down;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             ovf;
    logic             load_err;

    modport master (
        output enable, up_down, load, load_value,
        input  q, tc, ovf, load_err
    );

    modport slave (
        input  enable, up_down, load, load_value,
        output q, tc, ovf, load_err
    );
endinterface

// File: rtl/param_updown_counter_next_calc.sv
// Combinational next-state of the modulo counter: load clamping, modulo
// up/down stepping with wrap or saturate, and the flag conditions.
module counter_next_calc
    import counter_pkg::*;
#(
    parameter int     WIDTH    = 4,
    parameter longint MODULUS  = 16,
    parameter int     SATURATE = MODE_WRAP
) (
    input  logic [WIDTH-1:0] q,
    input  logic             enable,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] q_next,
    output logic             ovf_next,
    output logic             load_err_next
);
    localparam logic [WIDTH-1:0] Q_MAX       = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ONE         = WIDTH'(1);
    localparam bit               HOLD_AT_END = (SATURATE == MODE_SAT);

    always_comb begin
        q_next        = q;
        ovf_next      = 1'b0;
        load_err_next = 1'b0;
        if (load) begin
            // load_value > Q_MAX is the same test as load_value >= MODULUS
            if (load_value > Q_MAX) begin
                q_next        = Q_MAX;
                load_err_next = 1'b1;
            end else begin
                q_next = load_value;
            end
        end else if (enable) begin
            if (up_down == DIR_UP) begin
                if (q == Q_MAX) begin
                    ovf_next = 1'b1;
                    q_next   = HOLD_AT_END ? Q_MAX : '0;
                end else begin
                    q_next = q + ONE;
                end
            end else begin
                if (q == '0) begin
                    ovf_next = 1'b1;
                    q_next   = HOLD_AT_END ? '0 : Q_MAX;
                end else begin
                    q_next = q - ONE;
                end
            end
        end
    end

endmodule

// File: rtl/param_updown_counter.sv
// Parametrised modulo up/down counter with parallel load, wrap/saturate
// mode, terminal count and registered overflow / load-error pulses.
module param_updown_counter
    import counter_pkg::*;
#(
    parameter int     WIDTH    = 4,
    parameter longint MODULUS  = 16,
    parameter int     SATURATE = MODE_WRAP
) (
    input  logic                    clock,
    input  logic                    clear,
    param_updown_counter_if.slave   bus
);
    localparam logic [WIDTH-1:0] Q_MAX = WIDTH'(MODULUS - 1);

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $fatal(1, "param_updown_counter: WIDTH=%0d outside 2..32", WIDTH);
    end
    if (MODULUS < 2 || MODULUS > (longint'(1) << WIDTH)) begin : g_bad_modulus
        $fatal(1, "param_updown_counter: MODULUS=%0d outside 2..2**WIDTH", MODULUS);
    end
    if (SATURATE != MODE_WRAP && SATURATE != MODE_SAT) begin : g_bad_mode
        $fatal(1, "param_updown_counter: SATURATE=%0d must be 0 or 1", SATURATE);
    end

    logic [WIDTH-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             load_err_q, load_err_d;

    counter_next_calc #(
        .WIDTH    (WIDTH),
        .MODULUS  (MODULUS),
        .SATURATE (SATURATE)
    ) u_next_calc (
        .q             (count_q),
        .enable        (bus.enable),
        .up_down       (bus.up_down),
        .load          (bus.load),
        .load_value    (bus.load_value),
        .q_next        (count_d),
        .ovf_next      (ovf_d),
        .load_err_next (load_err_d)
    );

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            count_q    <= '0;
            ovf_q      <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            load_err_q <= load_err_d;
        end
    end

    // tc looks at the live direction so a direction change shows at once
    assign bus.tc       = (bus.up_down == DIR_UP) ? (count_q == Q_MAX) : (count_q == '0);
    assign bus.q        = count_q;
    assign bus.ovf      = ovf_q;
    assign bus.load_err = load_err_q;

endmodule

// File: tb/tb_param_updown_counter.sv
// Bench for param_updown_counter: a wrap and a saturate instance (WIDTH=4,
// MODULUS=10) driven in lockstep against a queued reference model.
module tb_param_updown_counter;

    localparam int MOD = 10;

    logic clock = 1'b0;
    logic clear = 1'b1;
    always #10 clock = ~clock;

    param_updown_counter_if #(.WIDTH(4)) if_w ();
    param_updown_counter_if #(.WIDTH(4)) if_s ();

    param_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) dut_w (
        .clock (clock), .clear (clear), .bus (if_w.slave)
    );
    param_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) dut_s (
        .clock (clock), .clear (clear), .bus (if_s.slave)
    );

    typedef struct packed {
        logic [3:0] qw;
        logic       ow;
        logic       lw;
        logic [3:0] qs;
        logic       os;
        logic       ls;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   mq_w    = 0;
    int   mq_s    = 0;
    logic cur_ud  = 1'b1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic exp_tc(input int qv, input logic ud);
        return ud ? (qv == MOD - 1) : (qv == 0);
    endfunction

    // Reference: one edge of a modulo-MOD counter given inputs and mode
    task automatic model_edge(input logic en, input logic ud, input logic ld, input int lv,
                              input bit sat, inout int st, output logic ov, output logic le);
        ov = 1'b0;
        le = 1'b0;
        if (ld) begin
            if (lv >= MOD) begin st = MOD - 1; le = 1'b1; end
            else st = lv;
        end else if (en) begin
            if (ud) begin
                if (st + 1 >= MOD) begin ov = 1'b1; st = sat ? MOD - 1 : 0; end
                else st = st + 1;
            end else begin
                if (st - 1 < 0) begin ov = 1'b1; st = sat ? 0 : MOD - 1; end
                else st = st - 1;
            end
        end
    endtask

    task automatic drive(input logic en, input logic ud, input logic ld, input int lv);
        exp_t e;
        logic ov, le;
        if_w.enable = en; if_w.up_down = ud; if_w.load = ld; if_w.load_value = 4'(lv);
        if_s.enable = en; if_s.up_down = ud; if_s.load = ld; if_s.load_value = 4'(lv);
        cur_ud = ud;
        model_edge(en, ud, ld, lv, 1'b0, mq_w, ov, le);
        e.qw = 4'(mq_w); e.ow = ov; e.lw = le;
        model_edge(en, ud, ld, lv, 1'b1, mq_s, ov, le);
        e.qs = 4'(mq_s); e.os = ov; e.ls = le;
        exp_q.push_back(e);
    endtask

    task automatic check_edge(input string tag);
        exp_t e;
        @(posedge clock);
        #1;
        if (exp_q.size() == 0) begin
            check_val({tag, "_queue_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check_val({tag, "_q_wrap"},    32'(if_w.q),        32'(e.qw));
            check_val({tag, "_ovf_wrap"},  32'(if_w.ovf),      32'(e.ow));
            check_val({tag, "_lerr_wrap"}, 32'(if_w.load_err), 32'(e.lw));
            check_val({tag, "_tc_wrap"},   32'(if_w.tc),       32'(exp_tc(int'(e.qw), cur_ud)));
            check_val({tag, "_q_sat"},     32'(if_s.q),        32'(e.qs));
            check_val({tag, "_ovf_sat"},   32'(if_s.ovf),      32'(e.os));
            check_val({tag, "_lerr_sat"},  32'(if_s.load_err), 32'(e.ls));
            check_val({tag, "_tc_sat"},    32'(if_s.tc),       32'(exp_tc(int'(e.qs), cur_ud)));
        end
    endtask

    task automatic cycle(input string tag, input logic en, input logic ud, input logic ld, input int lv);
        @(negedge clock);
        drive(en, ud, ld, lv);
        check_edge(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        if_w.enable = 1'b1; if_w.up_down = 1'b1; if_w.load = 1'b0; if_w.load_value = '0;
        if_s.enable = 1'b1; if_s.up_down = 1'b1; if_s.load = 1'b0; if_s.load_value = '0;

        // Reset state while clear is held
        #5;
        check_val("rst_q",    32'(if_w.q),        32'd0);
        check_val("rst_ovf",  32'(if_w.ovf),      32'd0);
        check_val("rst_lerr", 32'(if_w.load_err), 32'd0);
        check_val("rst_tc_up", 32'(if_w.tc),      32'd0);
        if_w.up_down = 1'b0;
        #1;
        check_val("rst_tc_down", 32'(if_w.tc),    32'd1);
        if_w.up_down = 1'b1;
        #25;
        check_val("rst_hold_q", 32'(if_w.q),      32'd0);
        #3;
        clear = 1'b0;

        // Scenario 1: count up through the wrap
        for (int i = 0; i < 12; i++) cycle("up", 1'b1, 1'b1, 1'b0, 0);

        // Scenario 2: count down from 0
        cycle("ld0", 1'b0, 1'b0, 1'b1, 0);
        for (int i = 0; i < 3; i++) cycle("down", 1'b1, 1'b0, 1'b0, 0);

        // Scenario 3: load beats count
        cycle("ld3", 1'b1, 1'b1, 1'b1, 3);
        cycle("ld7", 1'b1, 1'b1, 1'b1, 7);
        cycle("after_ld", 1'b1, 1'b1, 1'b0, 0);

        // Scenario 4: out-of-range load clamps, then a normal load
        cycle("ld12", 1'b0, 1'b1, 1'b1, 12);
        cycle("ld5", 1'b0, 1'b1, 1'b1, 5);
        cycle("hold", 1'b0, 1'b1, 1'b0, 0);
        cycle("ld15", 1'b1, 1'b0, 1'b1, 15);

        // Scenario 5: saturation at top, then reverse direction
        cycle("ld8", 1'b0, 1'b1, 1'b1, 8);
        for (int i = 0; i < 4; i++) cycle("sat_up", 1'b1, 1'b1, 1'b0, 0);
        cycle("sat_rev", 1'b1, 1'b0, 1'b0, 0);
        cycle("ld0b", 1'b0, 1'b0, 1'b1, 0);
        for (int i = 0; i < 2; i++) cycle("sat_dn", 1'b1, 1'b0, 1'b0, 0);

        // Scenario 6: asynchronous clear mid-cycle at q = 6
        cycle("ld6", 1'b0, 1'b1, 1'b1, 6);
        @(negedge clock);
        drive(1'b1, 1'b1, 1'b0, 0);
        #4;
        clear = 1'b1;
        #1;
        mq_w = 0;
        mq_s = 0;
        exp_q.delete();
        check_val("clr_async_q",    32'(if_w.q),        32'd0);
        check_val("clr_async_q_s",  32'(if_s.q),        32'd0);
        check_val("clr_async_ovf",  32'(if_w.ovf),      32'd0);
        check_val("clr_async_lerr", 32'(if_w.load_err), 32'd0);
        @(posedge clock); #1;
        check_val("clr_held1_q", 32'(if_w.q), 32'd0);
        @(posedge clock); #1;
        check_val("clr_held2_q", 32'(if_w.q), 32'd0);
        check_val("clr_held2_ovf", 32'(if_w.ovf), 32'd0);
        #4;
        clear = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 0);
        check_edge("resume1");
        for (int i = 0; i < 2; i++) cycle("resume", 1'b1, 1'b1, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/param_updown_counter.md
# param_updown_counter

Parametrised synchronous up/down counter. It succeeds the 4-bit ripple counter in the Ch 6 dataflow modelling set and adds:
- configurable width and modulus
- direction control
- parallel load
- wrap or saturate mode
- terminal-count and overflow flags

It is intended as the general-purpose counter primitive for later chapter exercises: timers, dividers and address generators.

## Interface
Parameters:
- WIDTH, 4: counter width in bits; legal range 2 to 32.
- MODULUS, 16: count range is 0 to MODULUS-1; legal range 2 to 2**WIDTH.
- SATURATE, 0: 0 = wrap at terminal count, 1 = hold at terminal count.

Ports:
- clock  input  1  single clock; all state changes on its rising edge.
- clear  input  1  asynchronous, active-high reset.
- enable  input  1  count enable.
- up_down  input  1  1 = count up, 0 = count down.
- load  input  1  synchronous parallel load.
- load_value  input  WIDTH  value to load.
- q  output  WIDTH  current count (registered).
- tc  output  1  terminal count (combinational from q and up_down).
- ovf  output  1  registered one-cycle overflow/underflow pulse.
- load_err  output  1  registered one-cycle pulse when an out-of-range load is clamped.

## Operation
- Priority per edge: clear, then load, then enable count, then hold.
- clear high: q = 0, ovf = 0, load_err = 0 immediately, independent of clock. These values are held while clear is high.
- Load:
  - load = 1 and load_value < MODULUS: q takes load_value.
  - load = 1 and load_value >= MODULUS: q takes MODULUS-1 and load_err pulses.
  - Load ignores enable and up_down, and never sets ovf.
- Count up (enable = 1, up_down = 1):
  - q < MODULUS-1: q + 1.
  - q = MODULUS-1, wrap mode: q becomes 0 and ovf pulses.
  - q = MODULUS-1, saturate mode: q holds at MODULUS-1 and ovf pulses.
- Count down (enable = 1, up_down = 0):
  - q > 0: q - 1.
  - q = 0, wrap mode: q becomes MODULUS-1 and ovf pulses.
  - q = 0, saturate mode: q holds at 0 and ovf pulses.
- enable = 0 and load = 0: q holds and ovf = 0.
- Arithmetic is modulo MODULUS, not 2**WIDTH. No intermediate value outside 0 to MODULUS-1 ever appears on q.
- tc = 1 when up_down = 1 and q = MODULUS-1, or when up_down = 0 and q = 0. tc does not depend on enable.
- Direction change takes effect on the next counting edge; there is no extra latency.
- Illegal parameters (MODULUS < 2 or MODULUS > 2**WIDTH) must stop elaboration with a fatal message.

## Timing
- Latency is one clock for both count and load: q updates at the rising edge where the controlling inputs were sampled.
- ovf and load_err are high for exactly the one cycle following the causing edge. Under a continuous saturate attempt, ovf stays high every cycle.
- Clear assertion is asynchronous: q drops to 0 at once, including mid-cycle.
- Clear release: the first count or load occurs at the first rising edge at which clear is sampled low. Release must meet normal setup to clock.
- Reset values: q = 0, ovf = 0, load_err = 0. tc follows q (tc = 1 after reset if up_down = 0).

## Structure
- Shared package `counter_pkg`:
  - mode constants MODE_WRAP = 0 and MODE_SAT = 1.
  - direction constants DIR_DOWN = 0 and DIR_UP = 1.
- Sub-module `counter_next_calc` is combinational. It takes q, up_down, load, load_value and the parameters, and returns next q, the ovf condition and the load_err condition. The top level holds only the registers and the async clear.

## Test plan
All scenarios use WIDTH = 4, MODULUS = 10, clock period 20 ns unless noted.
1. Clear high from t = 0 to 34 ns, then enable = 1, up_down = 1. Required: q = 0,1,…,9,0,1. tc = 1 only while q = 9. ovf pulses for the single cycle after the 9→0 edge.
2. Start from q = 0, enable = 1, up_down = 0. Required: q = 9,8,7. ovf pulses once after the 0→9 edge. tc = 1 while q = 0.
3. From q = 3 with enable = 1, assert load = 1 with load_value = 7 for one edge. Required: q = 7 (load wins over count), then q = 8 next edge, ovf never asserted.
4. Load load_value = 12. Required: q = 9 and load_err high for one cycle. A second load of 5 gives q = 5 with load_err = 0.
5. SATURATE = 1, counting up from 8. Required: q = 9,9,9. ovf high on every cycle after q reached 9 while enable stays 1. Switching to up_down = 0 gives q = 8.
6. Clear pulsed mid-cycle at q = 6 (e.g. 5 ns after an edge, held 50 ns). Required: q = 0 immediately and held during clear. Counting resumes 1,2,… from the first edge after release. ovf and load_err stay 0.
